alu_cmd_sequencer: RTL and testbench

Front-end sequencer for the combinational Mini ALU (alumain).
- Accepts commands {a, b, fxn} over a valid/ready handshake and buffers them in a small FIFO.
- Presents one command at a time to alumain, holds the operands stable for a settle window, then captures the ALU's 1-bit finalresult.
- Returns the result with an echo of the command over a valid/ready response channel.
- Sits directly upstream of alumain; alumain's result feeds back into it.

---
 rtl/alu_seq_pkg.sv | 29 ++
 rtl/alu_cmd_sequencer_if.sv | 28 ++
 rtl/alu_cmd_fifo.sv | 55 +++++
 rtl/alu_cmd_sequencer.sv | 153 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and constants for the alumain command sequencer
package alu_seq_pkg;

    localparam int W_DEF  = 6;
    localparam int FW_DEF = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } seq_state_t;

    // alumain function selects; every code yields a 1-bit compare result
    localparam logic [FW_DEF-1:0] FXN_AEQB  = 3'b000;
    localparam logic [FW_DEF-1:0] FXN_ANEB  = 3'b001;
    localparam logic [FW_DEF-1:0] FXN_AGTB  = 3'b010;
    localparam logic [FW_DEF-1:0] FXN_AGEB  = 3'b011;
    localparam logic [FW_DEF-1:0] FXN_ALT   = 3'b100;
    localparam logic [FW_DEF-1:0] FXN_ALEB  = 3'b101;
    localparam logic [FW_DEF-1:0] FXN_AZERO = 3'b110;
    localparam logic [FW_DEF-1:0] FXN_BZERO = 3'b111;

    typedef struct packed {
        logic [W_DEF-1:0]  a;
        logic [W_DEF-1:0]  b;
        logic [FW_DEF-1:0] fxn;
    } cmd_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - command and response handshake channels of the sequencer
interface alu_cmd_sequencer_if #(
    parameter int W  = 6,
    parameter int FW = 3
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_a;
    logic [W-1:0]  cmd_b;
    logic [FW-1:0] cmd_fxn;

    logic          resp_valid;
    logic          resp_ready;
    logic          resp_result;
    logic [W-1:0]  resp_a;
    logic [W-1:0]  resp_b;
    logic [FW-1:0] resp_fxn;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_fxn, resp_ready,
        output cmd_ready, resp_valid, resp_result, resp_a, resp_b, resp_fxn
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_fxn, resp_ready,
        input  cmd_ready, resp_valid, resp_result, resp_a, resp_b, resp_fxn
    );
endinterface

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO, no bypass, power-of-two depth
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter type word_t = cmd_t,
    parameter int  DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  word_t         push_data,
    input  logic          pop,
    output word_t         pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    word_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // pointers are exactly log2(DEPTH) wide so they wrap on their own
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - queues commands, drives alumain, captures and returns its result
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int  W      = W_DEF,
    parameter int  FW     = FW_DEF,
    parameter int  DEPTH  = 4,
    parameter int  SETTLE = 1,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    alu_cmd_sequencer_if.slave bus,
    output logic [W-1:0]       alu_a,
    output logic [W-1:0]       alu_b,
    output logic [FW-1:0]      alu_fxn,
    input  logic               alu_result,
    output logic [CW-1:0]      fifo_count,
    output logic               busy,
    output logic [7:0]         done_count
);

    localparam int SCW = $clog2(SETTLE + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("alu_cmd_sequencer: DEPTH must be a power of two >= 2");
    end
    if (SETTLE < 1) begin : g_bad_settle
        $error("alu_cmd_sequencer: SETTLE must be >= 1");
    end

    typedef struct packed {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [FW-1:0] fxn;
    } word_t;

    seq_state_t     state;
    seq_state_t     state_next;
    logic [SCW-1:0] settle_cnt;
    logic           pop;
    logic           capture;
    logic           resp_done;
    logic           fifo_full;
    logic           fifo_empty;
    word_t          push_word;
    word_t          head;

    logic           resp_valid_q;
    logic           resp_result_q;
    logic [W-1:0]   resp_a_q;
    logic [W-1:0]   resp_b_q;
    logic [FW-1:0]  resp_fxn_q;

    assign push_word     = '{a: bus.cmd_a, b: bus.cmd_b, fxn: bus.cmd_fxn};
    assign bus.cmd_ready = !fifo_full;

    alu_cmd_fifo #(
        .word_t (word_t),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.cmd_valid),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        resp_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == SCW'(SETTLE - 1)) begin
                    capture    = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    resp_done  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // operands only move on a pop, so alumain sees a stable input through SETTLE and RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt    <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_fxn       <= '0;
            resp_valid_q  <= 1'b0;
            resp_result_q <= 1'b0;
            resp_a_q      <= '0;
            resp_b_q      <= '0;
            resp_fxn_q    <= '0;
            done_count    <= '0;
        end else begin
            if (pop) begin
                alu_a      <= head.a;
                alu_b      <= head.b;
                alu_fxn    <= head.fxn;
                settle_cnt <= '0;
            end else if (state == S_SETTLE) begin
                settle_cnt <= settle_cnt + SCW'(1);
            end
            if (capture) begin
                resp_valid_q  <= 1'b1;
                resp_result_q <= alu_result;
                resp_a_q      <= alu_a;
                resp_b_q      <= alu_b;
                resp_fxn_q    <= alu_fxn;
            end else if (resp_done) begin
                resp_valid_q <= 1'b0;
            end
            if (resp_done) begin
                done_count <= done_count + 8'd1;
            end
        end
    end

    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_a      = resp_a_q;
    assign bus.resp_b      = resp_b_q;
    assign bus.resp_fxn    = resp_fxn_q;
    assign busy            = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer with an alumain model
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    localparam int W     = 6;
    localparam int FW    = 3;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int NV    = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    alu_cmd_sequencer_if #(.W(W), .FW(FW)) bus0 ();
    alu_cmd_sequencer_if #(.W(W), .FW(FW)) bus1 ();

    logic [W-1:0]  alu_a0, alu_b0, alu_a1, alu_b1;
    logic [FW-1:0] alu_fxn0, alu_fxn1;
    logic          alu_result0, alu_result1;
    logic [CW-1:0] fifo_count0, fifo_count1;
    logic          busy0, busy1;
    logic [7:0]    done_count0, done_count1;

    function automatic logic alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [FW-1:0] f);
        case (f)
            FXN_AEQB:  return a == b;
            FXN_ANEB:  return a != b;
            FXN_AGTB:  return a > b;
            FXN_AGEB:  return a >= b;
            FXN_ALT:   return a < b;
            FXN_ALEB:  return a <= b;
            FXN_AZERO: return a == '0;
            FXN_BZERO: return b == '0;
            default:   return 1'b0;
        endcase
    endfunction

    assign alu_result0 = alu_ref(alu_a0, alu_b0, alu_fxn0);
    assign alu_result1 = alu_ref(alu_a1, alu_b1, alu_fxn1);

    alu_cmd_sequencer #(.W(W), .FW(FW), .DEPTH(DEPTH), .SETTLE(1)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_fxn(alu_fxn0), .alu_result(alu_result0),
        .fifo_count(fifo_count0), .busy(busy0), .done_count(done_count0)
    );

    alu_cmd_sequencer #(.W(W), .FW(FW), .DEPTH(DEPTH), .SETTLE(3)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_fxn(alu_fxn1), .alu_result(alu_result1),
        .fifo_count(fifo_count1), .busy(busy1), .done_count(done_count1)
    );

    typedef struct packed {
        logic          result;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [FW-1:0] fxn;
    } rsp_t;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [FW-1:0] fxn;
        logic          exp;
    } vec_t;

    rsp_t sb0[$];
    rsp_t sb1[$];
    vec_t vecs[NV];
    int   errors = 0;
    int   checks = 0;
    int   nresp0 = 0;
    int   nresp1 = 0;
    logic [7:0] exp_done0 = 8'd0;
    logic [7:0] exp_done1 = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboards: sample each handshake on the falling edge before the edge that commits it
    initial forever begin
        rsp_t e;
        @(negedge clk);
        if (rst) begin
            sb0.delete();
            exp_done0 = 8'd0;
        end else begin
            if (bus0.resp_valid && bus0.resp_ready) begin
                nresp0++;
                exp_done0++;
                chk("sb0_nonempty", sb0.size() != 0, 1);
                if (sb0.size() != 0) begin
                    e = sb0.pop_front();
                    chk("sb0_resp", {bus0.resp_result, bus0.resp_a, bus0.resp_b, bus0.resp_fxn}, e);
                end
            end
            if (bus0.cmd_valid && bus0.cmd_ready)
                sb0.push_back({alu_ref(bus0.cmd_a, bus0.cmd_b, bus0.cmd_fxn),
                               bus0.cmd_a, bus0.cmd_b, bus0.cmd_fxn});
        end
    end

    initial forever begin
        rsp_t e;
        @(negedge clk);
        if (rst) begin
            sb1.delete();
            exp_done1 = 8'd0;
        end else begin
            if (bus1.resp_valid && bus1.resp_ready) begin
                nresp1++;
                exp_done1++;
                chk("sb1_nonempty", sb1.size() != 0, 1);
                if (sb1.size() != 0) begin
                    e = sb1.pop_front();
                    chk("sb1_resp", {bus1.resp_result, bus1.resp_a, bus1.resp_b, bus1.resp_fxn}, e);
                end
            end
            if (bus1.cmd_valid && bus1.cmd_ready)
                sb1.push_back({alu_ref(bus1.cmd_a, bus1.cmd_b, bus1.cmd_fxn),
                               bus1.cmd_a, bus1.cmd_b, bus1.cmd_fxn});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_op0(input int idx, input vec_t v);
        int n;
        bus0.cmd_a = v.a; bus0.cmd_b = v.b; bus0.cmd_fxn = v.fxn; bus0.cmd_valid = 1'b1;
        tick();
        bus0.cmd_valid = 1'b0;
        n = 0;
        while (!bus0.resp_valid && n < 20) begin tick(); n++; end
        chk($sformatf("vec%0d_resp_valid", idx), bus0.resp_valid, 1);
        chk($sformatf("vec%0d_result", idx), bus0.resp_result, v.exp);
        chk($sformatf("vec%0d_echo", idx), {bus0.resp_a, bus0.resp_b, bus0.resp_fxn}, {v.a, v.b, v.fxn});
        tick();
        chk($sformatf("vec%0d_done", idx), done_count0, exp_done0);
    endtask

    int  base;
    int  n;
    int  acc;
    int  seen;
    logic took;
    logic saw255;

    task automatic wrap_watch();
        if (!saw255 && nresp0 - base == 255) begin
            chk("wrap_done_255", done_count0, 255);
            saw255 = 1'b1;
        end
    endtask

    initial begin
        vecs[0] = '{6'd10, 6'd47, FXN_ALT,   1'b1};
        vecs[1] = '{6'd48, 6'd1,  FXN_ALT,   1'b0};
        vecs[2] = '{6'd5,  6'd5,  FXN_ALT,   1'b0};
        vecs[3] = '{6'd0,  6'd63, FXN_ALT,   1'b1};
        vecs[4] = '{6'd63, 6'd0,  FXN_ALT,   1'b0};
        vecs[5] = '{6'd5,  6'd5,  FXN_AEQB,  1'b1};
        vecs[6] = '{6'd5,  6'd6,  FXN_ANEB,  1'b1};
        vecs[7] = '{6'd40, 6'd39, FXN_AGTB,  1'b1};
        vecs[8] = '{6'd2,  6'd9,  FXN_AGTB,  1'b0};
        vecs[9] = '{6'd3,  6'd0,  FXN_BZERO, 1'b1};

        rst = 1'b1;
        bus0.cmd_valid = 1'b0; bus0.cmd_a = '0; bus0.cmd_b = '0; bus0.cmd_fxn = '0; bus0.resp_ready = 1'b1;
        bus1.cmd_valid = 1'b0; bus1.cmd_a = '0; bus1.cmd_b = '0; bus1.cmd_fxn = '0; bus1.resp_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;

        chk("rst_cmd_ready", bus0.cmd_ready, 1);
        chk("rst_fifo_count", fifo_count0, 0);
        chk("rst_resp_valid", bus0.resp_valid, 0);
        chk("rst_resp_fields", {bus0.resp_result, bus0.resp_a, bus0.resp_b, bus0.resp_fxn}, 0);
        chk("rst_alu", {alu_a0, alu_b0, alu_fxn0}, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done_count0, 0);

        // single op with exact latency
        bus0.cmd_a = 6'b001010; bus0.cmd_b = 6'b101111; bus0.cmd_fxn = FXN_ALT; bus0.cmd_valid = 1'b1;
        tick();
        bus0.cmd_valid = 1'b0;
        chk("single_count_e0", fifo_count0, 1);
        chk("single_alu_e0", {alu_a0, alu_b0, alu_fxn0}, 0);
        tick();
        chk("single_alu_e1", {alu_a0, alu_b0, alu_fxn0}, {6'b001010, 6'b101111, FXN_ALT});
        chk("single_valid_e1", bus0.resp_valid, 0);
        chk("single_busy_e1", busy0, 1);
        tick();
        chk("single_valid_e2", bus0.resp_valid, 1);
        chk("single_result_e2", bus0.resp_result, 1);
        chk("single_echo_e2", {bus0.resp_a, bus0.resp_b, bus0.resp_fxn}, {6'b001010, 6'b101111, FXN_ALT});
        tick();
        chk("single_valid_e3", bus0.resp_valid, 0);
        chk("single_done_e3", done_count0, 1);

        for (int i = 0; i < NV; i++) do_op0(i, vecs[i]);

        // FIFO fill under back-pressure
        bus0.resp_ready = 1'b0;
        base = nresp0;
        for (int i = 0; i < 5; i++) begin
            bus0.cmd_a = 6'(i * 7 + 1); bus0.cmd_b = 6'(40 - i * 3); bus0.cmd_fxn = 3'(i);
            bus0.cmd_valid = 1'b1;
            chk($sformatf("fill_ready_%0d", i), bus0.cmd_ready, 1);
            tick();
        end
        bus0.cmd_a = 6'd50; bus0.cmd_b = 6'd51; bus0.cmd_fxn = FXN_ALT;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("fill_full_ready_%0d", i), bus0.cmd_ready, 0);
            chk($sformatf("fill_full_count_%0d", i), fifo_count0, 4);
            chk($sformatf("fill_head_resp_%0d", i), {bus0.resp_valid, bus0.resp_a}, {1'b1, 6'd1});
            tick();
        end
        bus0.resp_ready = 1'b1;
        n = 0;
        while (!bus0.cmd_ready && n < 20) begin tick(); n++; end
        chk("fill_6th_ready", bus0.cmd_ready, 1);
        tick();
        bus0.cmd_valid = 1'b0;
        n = 0;
        while ((busy0 || bus0.resp_valid) && n < 100) begin tick(); n++; end
        chk("fill_drained", busy0 || bus0.resp_valid, 0);
        chk("fill_nresp", nresp0 - base, 6);
        chk("fill_done", done_count0, exp_done0);

        // response stall
        bus0.resp_ready = 1'b0;
        base = nresp0;
        bus0.cmd_a = 6'd33; bus0.cmd_b = 6'd12; bus0.cmd_fxn = FXN_AGTB; bus0.cmd_valid = 1'b1;
        tick();
        bus0.cmd_valid = 1'b0;
        n = 0;
        while (!bus0.resp_valid && n < 20) begin tick(); n++; end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_resp_%0d", i),
                {bus0.resp_valid, bus0.resp_result, bus0.resp_a, bus0.resp_b, bus0.resp_fxn},
                {1'b1, 1'b1, 6'd33, 6'd12, FXN_AGTB});
            chk($sformatf("stall_alu_%0d", i), {alu_a0, alu_b0, alu_fxn0}, {6'd33, 6'd12, FXN_AGTB});
            chk($sformatf("stall_done_%0d", i), done_count0, exp_done0);
            tick();
        end
        bus0.resp_ready = 1'b1;
        tick();
        chk("stall_release_valid", bus0.resp_valid, 0);
        chk("stall_release_done", done_count0, exp_done0);
        tick(); tick(); tick();
        chk("stall_single_resp", nresp0 - base, 1);

        // SETTLE=3 latency
        bus1.cmd_a = 6'b110000; bus1.cmd_b = 6'b000001; bus1.cmd_fxn = FXN_ALT; bus1.cmd_valid = 1'b1;
        tick();
        bus1.cmd_valid = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk($sformatf("s3_valid_e%0d", e), bus1.resp_valid, 0);
        end
        tick();
        chk("s3_valid_e4", bus1.resp_valid, 1);
        chk("s3_result_e4", bus1.resp_result, 0);
        chk("s3_echo_e4", {bus1.resp_a, bus1.resp_b, bus1.resp_fxn}, {6'b110000, 6'b000001, FXN_ALT});
        tick();
        chk("s3_done", done_count1, 1);

        // reset during SETTLE with two commands queued
        for (int i = 0; i < 3; i++) begin
            bus1.cmd_a = 6'(i + 20); bus1.cmd_b = 6'(i + 1); bus1.cmd_fxn = FXN_AGTB; bus1.cmd_valid = 1'b1;
            tick();
        end
        bus1.cmd_valid = 1'b0;
        chk("midrst_pre_count", fifo_count1, 2);
        chk("midrst_pre_busy", busy1, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_count", fifo_count1, 0);
        chk("midrst_valid", bus1.resp_valid, 0);
        chk("midrst_alu", {alu_a1, alu_b1, alu_fxn1}, 0);
        chk("midrst_busy", busy1, 0);
        chk("midrst_ready", bus1.cmd_ready, 1);
        chk("midrst_done", done_count1, 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus1.resp_valid) seen++;
        end
        chk("midrst_no_stale", seen, 0);

        // 256 completions wrap done_count back to zero
        base = nresp0;
        saw255 = 1'b0;
        acc = 0;
        n = 0;
        bus0.resp_ready = 1'b1;
        bus0.cmd_a = 6'($urandom); bus0.cmd_b = 6'($urandom); bus0.cmd_fxn = 3'($urandom);
        bus0.cmd_valid = 1'b1;
        while (acc < 256 && n < 5000) begin
            took = bus0.cmd_ready;
            tick();
            n++;
            wrap_watch();
            if (took) begin
                acc++;
                if (acc == 256) bus0.cmd_valid = 1'b0;
                else begin
                    bus0.cmd_a = 6'($urandom); bus0.cmd_b = 6'($urandom); bus0.cmd_fxn = 3'($urandom);
                end
            end
        end
        bus0.cmd_valid = 1'b0;
        chk("wrap_all_pushed", acc, 256);
        n = 0;
        while ((busy0 || bus0.resp_valid) && n < 200) begin tick(); n++; wrap_watch(); end
        chk("wrap_drained", busy0 || bus0.resp_valid, 0);
        chk("wrap_nresp", nresp0 - base, 256);
        chk("wrap_seen_255", saw255, 1);
        chk("wrap_done_zero", done_count0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
